ttt_move_scheduler: RTL and testbench

Arbitrates tic-tac-toe move requests from two player input controllers and owns the 3×3 board register read by the pixel renderer. Legal moves are committed only during vertical blanking, so each displayed frame shows one consistent board. It sits between the player input logic and the renderer, and is clocked by the pixel clock alongside the horizontal/vertical counters.

---
 rtl/ttt_move_scheduler_if.sv | 22 ++
 rtl/ttt_move_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_ttt_move_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_move_scheduler_if.sv
// Move request/response handshake between the two player input controllers
// and the move scheduler.
interface ttt_move_scheduler_if;
  logic       p1_req;
  logic [3:0] p1_cell;
  logic       p1_ack;
  logic       p1_nack;
  logic       p2_req;
  logic [3:0] p2_cell;
  logic       p2_ack;
  logic       p2_nack;

  modport master (
    output p1_req, p1_cell, p2_req, p2_cell,
    input  p1_ack, p1_nack, p2_ack, p2_nack
  );

  modport slave (
    input  p1_req, p1_cell, p2_req, p2_cell,
    output p1_ack, p1_nack, p2_ack, p2_nack
  );
endinterface

// File: rtl/ttt_move_scheduler.sv
// Tic-tac-toe move arbiter and board owner; board writes land only in vertical blanking.
// Optional TTT_AUTO_RESTART_EN: clear the board FRAMES_RESTART frames after game over.
module ttt_move_scheduler #(
  parameter int unsigned V_VISIBLE = 480
`ifdef TTT_AUTO_RESTART_EN
  , parameter int unsigned FRAMES_RESTART = 120
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           vcount,
  input  logic                 new_game,
  ttt_move_scheduler_if.slave  mv,
  output logic [17:0]          board,
  output logic                 turn,
  output logic                 game_over,
  output logic [1:0]           winner
);

  typedef enum logic [2:0] {IDLE, WAIT_BLANK, COMMIT, EVAL, OVER} state_t;

  localparam logic [9:0]  V_VIS = 10'(V_VISIBLE);
  // Each entry packs the three cell indices of one winning line.
  localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                        12'h147, 12'h258, 12'h048, 12'h246};

  state_t     state;
  logic       armed1, armed2;
  logic       ng_pend;
  logic [3:0] lat_cell;

  logic       in_blank;
  logic       cur_req;
  logic [3:0] cur_cell;
  logic [1:0] mark;
  logic       cell_free;
  logic       win;
  logic       full;
  logic       auto_fire;
  logic       do_clear;

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[2*i +: 2];
  endfunction

  assign in_blank = (vcount >= V_VIS);
  assign cur_req  = turn ? (mv.p2_req & armed2) : (mv.p1_req & armed1);
  assign cur_cell = turn ? mv.p2_cell : mv.p1_cell;
  assign mark     = turn ? 2'b10 : 2'b01;
  assign do_clear = in_blank & (ng_pend | new_game | auto_fire);

  always_comb begin
    win       = 1'b0;
    full      = 1'b1;
    cell_free = 1'b0;
    for (int unsigned l = 0; l < 8; l++) begin
      if (cell_at(board, LINES[l][11:8]) == mark &&
          cell_at(board, LINES[l][7:4])  == mark &&
          cell_at(board, LINES[l][3:0])  == mark)
        win = 1'b1;
    end
    for (int unsigned i = 0; i < 9; i++) begin
      if (board[2*i +: 2] == 2'b00) begin
        full = 1'b0;
        if (cur_cell == 4'(i))
          cell_free = 1'b1;
      end
    end
  end

`ifdef TTT_AUTO_RESTART_EN
  logic       blank_d;
  logic [7:0] frame_cnt;

  assign auto_fire = (state == OVER) && (frame_cnt >= 8'(FRAMES_RESTART));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_d   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      blank_d <= in_blank;
      if (state != OVER)
        frame_cnt <= '0;
      else if (in_blank && !blank_d && frame_cnt != '1)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      armed1     <= 1'b0;
      armed2     <= 1'b0;
      ng_pend    <= 1'b0;
      lat_cell   <= '0;
      board      <= '0;
      turn       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      mv.p1_ack  <= 1'b0;
      mv.p1_nack <= 1'b0;
      mv.p2_ack  <= 1'b0;
      mv.p2_nack <= 1'b0;
    end else begin
      mv.p1_ack  <= 1'b0;
      mv.p1_nack <= 1'b0;
      mv.p2_ack  <= 1'b0;
      mv.p2_nack <= 1'b0;
      if (!mv.p1_req) armed1 <= 1'b1;
      if (!mv.p2_req) armed2 <= 1'b1;
      if (new_game)   ng_pend <= 1'b1;

      // A clear overrides whatever the state would otherwise do this cycle,
      // so the later assignments to armed/ng_pend below intentionally win.
      if (do_clear && (state == IDLE || state == WAIT_BLANK || state == OVER)) begin
        board     <= '0;
        turn      <= 1'b0;
        game_over <= 1'b0;
        winner    <= 2'b00;
        ng_pend   <= 1'b0;
        state     <= IDLE;
        if (state == WAIT_BLANK) begin
          if (turn) begin
            mv.p2_nack <= 1'b1;
            armed2     <= 1'b0;
          end else begin
            mv.p1_nack <= 1'b1;
            armed1     <= 1'b0;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (cur_req) begin
              lat_cell <= cur_cell;
              if (cell_free)
                state <= WAIT_BLANK;
              else if (turn) begin
                mv.p2_nack <= 1'b1;
                armed2     <= 1'b0;
              end else begin
                mv.p1_nack <= 1'b1;
                armed1     <= 1'b0;
              end
            end
          end
          WAIT_BLANK: begin
            if (in_blank)
              state <= COMMIT;
          end
          COMMIT: begin
            if (in_blank) begin
              board[2*lat_cell +: 2] <= mark;
              state                  <= EVAL;
              if (turn) begin
                mv.p2_ack <= 1'b1;
                armed2    <= 1'b0;
              end else begin
                mv.p1_ack <= 1'b1;
                armed1    <= 1'b0;
              end
            end else begin
              state <= WAIT_BLANK;
            end
          end
          EVAL: begin
            if (win) begin
              winner    <= mark;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (full) begin
              winner    <= 2'b11;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              turn  <= ~turn;
              state <= IDLE;
            end
          end
          OVER: begin
            if (mv.p1_req && armed1) begin
              mv.p1_nack <= 1'b1;
              armed1     <= 1'b0;
            end
            if (mv.p2_req && armed2) begin
              mv.p2_nack <= 1'b1;
              armed2     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_move_scheduler.sv
// Directed bench for ttt_move_scheduler: per-player scoreboards of expected
// ack/nack and board contents, checked when the scheduler responds.
module tb_ttt_move_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  vcount;
  logic        new_game;
  logic [17:0] board;
  logic        turn;
  logic        game_over;
  logic [1:0]  winner;

  ttt_move_scheduler_if mv ();

  ttt_move_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .vcount    (vcount),
    .new_game  (new_game),
    .mv        (mv.slave),
    .board     (board),
    .turn      (turn),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;
    bit          ack;
    logic [17:0] board;
  } exp_t;

  exp_t        sb1[$];
  exp_t        sb2[$];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] mb;
  bit          mover_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void push_exp(input int p, input int c);
    exp_t e;
    e.p   = p;
    e.ack = 1'b0;
    if (!mover_over && c <= 8) begin
      if (mb[2*c +: 2] == 2'b00) begin
        mb[2*c +: 2] = (p == 1) ? 2'b01 : 2'b10;
        e.ack = 1'b1;
      end
    end
    e.board = mb;
    if (p == 1) sb1.push_back(e);
    else        sb2.push_back(e);
  endfunction

  task automatic drive(input int p, input int c);
    if (p == 1) begin
      mv.p1_cell = 4'(c);
      mv.p1_req  = 1'b1;
    end else begin
      mv.p2_cell = 4'(c);
      mv.p2_req  = 1'b1;
    end
  endtask

  task automatic wait_resp(input int p, input int exp_lat, input string tag);
    exp_t e;
    int   n;
    bit   got;
    bit   a;
    n   = 0;
    got = 1'b0;
    a   = 1'b0;
    if (p == 1) e = sb1.pop_front();
    else        e = sb2.pop_front();
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (p == 1 && (mv.p1_ack || mv.p1_nack)) begin got = 1'b1; a = mv.p1_ack; end
      if (p == 2 && (mv.p2_ack || mv.p2_nack)) begin got = 1'b1; a = mv.p2_ack; end
    end
    if (p == 1) mv.p1_req = 1'b0;
    else        mv.p2_req = 1'b0;
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_ack"}, 32'(a), 32'(e.ack));
      check({tag, "_board"}, 32'(board), 32'(e.board));
      if (exp_lat > 0)
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    end
    @(negedge clk);
    if (p == 1) check({tag, "_width"}, {30'd0, mv.p1_ack, mv.p1_nack}, 32'd0);
    else        check({tag, "_width"}, {30'd0, mv.p2_ack, mv.p2_nack}, 32'd0);
  endtask

  task automatic play(input int p, input int c, input int lat, input string tag);
    push_exp(p, c);
    drive(p, c);
    wait_resp(p, lat, tag);
  endtask

  initial begin
    bit quiet;
    vcount     = 10'd0;
    new_game   = 1'b0;
    mv.p1_req  = 1'b0;
    mv.p2_req  = 1'b0;
    mv.p1_cell = 4'd0;
    mv.p2_cell = 4'd0;
    mb         = '0;
    mover_over = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_board", 32'(board), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_acks", {28'd0, mv.p1_ack, mv.p1_nack, mv.p2_ack, mv.p2_nack}, 32'd0);

    // Legal move issued in the visible region must wait for blanking.
    vcount = 10'd100;
    push_exp(1, 4);
    drive(1, 4);
    quiet = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (board != '0 || mv.p1_ack || mv.p1_nack) quiet = 1'b0;
    end
    vcount = 10'd479;
    repeat (15) begin
      @(negedge clk);
      if (board != '0 || mv.p1_ack || mv.p1_nack) quiet = 1'b0;
    end
    check("visible_hold", 32'(quiet), 32'd1);
    vcount = 10'd480;
    wait_resp(1, 2, "p1_c4");
    check("turn_after_p1", 32'(turn), 32'd1);

    play(2, 4, 1, "p2_occupied");
    check("turn_after_occ", 32'(turn), 32'd1);
    play(2, 8, 3, "p2_c8");
    check("turn_after_p2", 32'(turn), 32'd0);
    play(1, 12, 1, "p1_cell12");
    check("turn_after_ill", 32'(turn), 32'd0);

    // Off-turn request stays pending until p1 has moved.
    mv.p2_cell = 4'd0;
    mv.p2_req  = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mv.p2_ack || mv.p2_nack) quiet = 1'b0;
    end
    check("offturn_quiet", 32'(quiet), 32'd1);
    play(1, 2, 3, "p1_c2");
    push_exp(2, 0);
    wait_resp(2, 0, "p2_held");
    check("turn_after_held", 32'(turn), 32'd0);

    // new_game while a move waits for blanking: move discarded with nack.
    vcount = 10'd100;
    drive(1, 5);
    repeat (3) @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    repeat (3) @(negedge clk);
    check("ng_board_vis", 32'(board), 32'(mb));
    mb = '0;
    sb1.push_back('{p: 1, ack: 1'b0, board: 18'd0});
    vcount = 10'd480;
    wait_resp(1, 1, "ng_discard");
    check("ng_turn", 32'(turn), 32'd0);

    // X wins on the top row.
    play(1, 0, 3, "w_x0");
    play(2, 3, 3, "w_o3");
    play(1, 1, 3, "w_x1");
    play(2, 4, 3, "w_o4");
    check("w_not_over", 32'(game_over), 32'd0);
    play(1, 2, 3, "w_x2");
    check("w_over", 32'(game_over), 32'd1);
    check("w_winner", 32'(winner), 32'd1);
    mover_over = 1'b1;
    play(2, 5, 1, "over_p2");
    play(1, 6, 1, "over_p1");

    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    check("ng_clear_board", 32'(board), 32'd0);
    check("ng_clear_over", {30'd0, game_over, turn}, 32'd0);
    check("ng_clear_winner", 32'(winner), 32'd0);
    mb = '0;
    mover_over = 1'b0;

    // Draw: X 0,2,3,7,8  O 1,4,5,6.
    play(1, 0, 3, "d_x0");
    play(2, 1, 3, "d_o1");
    play(1, 2, 3, "d_x2");
    play(2, 4, 3, "d_o4");
    play(1, 3, 3, "d_x3");
    play(2, 5, 3, "d_o5");
    play(1, 7, 3, "d_x7");
    play(2, 6, 3, "d_o6");
    check("d_not_over", 32'(game_over), 32'd0);
    play(1, 8, 3, "d_x8");
    check("d_over", 32'(game_over), 32'd1);
    check("d_winner", 32'(winner), 32'd3);
    mover_over = 1'b1;

`ifdef TTT_AUTO_RESTART_EN
    for (int f = 0; f < 119; f++) begin
      vcount = 10'd100;
      repeat (2) @(negedge clk);
      vcount = 10'd480;
      repeat (2) @(negedge clk);
    end
    check("auto_hold_board", 32'(board), 32'(mb));
    check("auto_hold_over", 32'(game_over), 32'd1);
    vcount = 10'd100;
    repeat (2) @(negedge clk);
    vcount = 10'd480;
    repeat (3) @(negedge clk);
    check("auto_clear_board", 32'(board), 32'd0);
    check("auto_clear_over", 32'(game_over), 32'd0);
`else
    repeat (20) @(negedge clk);
    check("over_persists", 32'(game_over), 32'd1);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    check("ng2_clear_board", 32'(board), 32'd0);
`endif
    mb = '0;
    mover_over = 1'b0;

    // Reset in the middle of a pending move clears everything silently.
    play(1, 4, 3, "r_x4");
    vcount     = 10'd100;
    mv.p2_cell = 4'd5;
    mv.p2_req  = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_board", 32'(board), 32'd0);
    check("midrst_turn", 32'(turn), 32'd0);
    mv.p2_req = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    vcount = 10'd480;
    quiet  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mv.p1_ack || mv.p1_nack || mv.p2_ack || mv.p2_nack || board != '0) quiet = 1'b0;
    end
    check("midrst_quiet", 32'(quiet), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
